i2c_master_arbiter: RTL and testbench

Sequences and shares the single i2c_master instance between N_REQ on-chip requesters. Each request is one single-byte I2C transaction (7-bit address, R/W bit, one data byte). The block round-robin arbitrates, drives the master's start/stop/rw/addr/w_data command inputs, and waits for completion or timeout. It then returns a one-cycle response (read data, NACK, timeout flags) to the winning requester.

---
 rtl/i2c_pkg.sv | 20 ++
 rtl/i2c_master_arbiter_if.sv | 38 +++
 rtl/rr_arbiter.sv | 28 ++
 rtl/i2c_master_arbiter.sv | 98 +++++++++
 tb/tb_i2c_master_arbiter.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master arbiter slice.
package i2c_pkg;

  localparam int I2C_ADDR_W         = 7;
  localparam int I2C_DATA_W         = 8;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Modulo-n increment used for the round-robin pointer.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/i2c_master_arbiter_if.sv
// Requester and i2c_master command/status bundle; master = arbiter view, slave = environment view.
interface i2c_master_arbiter_if #(
  parameter int N_REQ = 4
) ();
  import i2c_pkg::*;

  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [I2C_ADDR_W*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]            req_rw;
  logic [I2C_DATA_W*N_REQ-1:0] req_wdata;
  logic [N_REQ-1:0]            rsp_valid;
  logic [I2C_DATA_W-1:0]       rsp_rdata;
  logic                        rsp_nack;
  logic                        rsp_timeout;
  logic                        m_start;
  logic                        m_stop;
  logic                        m_rw;
  logic [I2C_ADDR_W-1:0]       m_addr;
  logic [I2C_DATA_W-1:0]       m_wdata;
  logic                        m_busy;
  logic                        m_done;
  logic                        m_nack;
  logic [I2C_DATA_W-1:0]       m_rdata;

  modport master (
    input  req_valid, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           m_start, m_stop, m_rw, m_addr, m_wdata
  );

  modport slave (
    output req_valid, req_addr, req_rw, req_wdata, m_busy, m_done, m_nack, m_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_nack, rsp_timeout,
           m_start, m_stop, m_rw, m_addr, m_wdata
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from rr_ptr, wrapping.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [PTR_W-1:0] grant,
  output logic             any_req
);

  // Scan downward in distance so the closest request to rr_ptr is written last.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req_valid[idx]) begin
        any_req = 1'b1;
        grant   = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one i2c_master among N_REQ requesters: round-robin grant, command issue, completion/timeout wait, response.
module i2c_master_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  i2c_master_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  arb_state_t       state;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] grant;
  logic [PTR_W-1:0] gnt_q;
  logic             any_req;
  logic [CNT_W-1:0] tmo_cnt;

  function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_req   (any_req)
  );

  // Accept and start are same-cycle decodes; gating with reset keeps them low while held in reset.
  assign bus.req_ready = (reset && state == ST_IDLE && any_req) ? onehot(grant) : '0;
  assign bus.m_start   = (state == ST_ISSUE) && !bus.m_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= ST_IDLE;
      rr_ptr          <= '0;
      gnt_q           <= '0;
      tmo_cnt         <= '0;
      bus.m_stop      <= 1'b0;
      bus.m_rw        <= 1'b0;
      bus.m_addr      <= '0;
      bus.m_wdata     <= '0;
      bus.rsp_valid   <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_nack    <= 1'b0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.rsp_valid   <= '0;
      bus.rsp_rdata   <= '0;
      bus.rsp_nack    <= 1'b0;
      bus.rsp_timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            gnt_q       <= grant;
            bus.m_addr  <= bus.req_addr[int'(grant)*I2C_ADDR_W +: I2C_ADDR_W];
            bus.m_rw    <= bus.req_rw[grant];
            bus.m_wdata <= bus.req_wdata[int'(grant)*I2C_DATA_W +: I2C_DATA_W];
            bus.m_stop  <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!bus.m_busy) state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Completion takes priority over a timeout landing in the same cycle.
          if (bus.m_done) begin
            bus.rsp_valid <= onehot(gnt_q);
            bus.rsp_nack  <= bus.m_nack;
            bus.rsp_rdata <= bus.m_rw ? bus.m_rdata : '0;
            bus.m_stop    <= 1'b0;
            state         <= ST_RESP;
          end else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            bus.rsp_valid   <= onehot(gnt_q);
            bus.rsp_timeout <= 1'b1;
            bus.m_stop      <= 1'b0;
            state           <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr  <= PTR_W'(wrap_inc(int'(gnt_q), N_REQ));
          tmo_cnt <= '0;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with N_REQ=4, TIMEOUT_CYCLES=64.
module tb_i2c_master_arbiter;

  logic clk;
  logic reset;
  int   n_asserts;
  int   n_fail;

  i2c_master_arbiter_if #(.N_REQ(4)) bus ();

  i2c_master_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end of the directed sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction starting in IDLE with a free master; finishes one cycle after the response.
  task automatic txn(input int g, input logic [6:0] ea, input logic ew, input logic [7:0] ewd,
                     input logic nack, input logic [7:0] rd, input logic [7:0] exp_rd,
                     input bit drop);
    #1;
    chk($sformatf("ready_g%0d", g), bus.req_ready, 32'(4'b0001 << g));
    chk("start_idle", bus.m_start, 0);
    tick();
    if (drop) bus.req_valid[g] = 1'b0;
    #1;
    chk("start_issue", bus.m_start, 1);
    chk("stop_issue", bus.m_stop, 1);
    chk($sformatf("addr_g%0d", g), bus.m_addr, ea);
    chk($sformatf("rw_g%0d", g), bus.m_rw, ew);
    chk($sformatf("wdata_g%0d", g), bus.m_wdata, ewd);
    tick();
    chk("start_wait", bus.m_start, 0);
    chk("stop_wait", bus.m_stop, 1);
    bus.m_done  = 1'b1;
    bus.m_nack  = nack;
    bus.m_rdata = rd;
    tick();
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = 8'h00;
    #1;
    chk($sformatf("rsp_valid_g%0d", g), bus.rsp_valid, 32'(4'b0001 << g));
    chk("rsp_nack", bus.rsp_nack, nack);
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_timeout", bus.rsp_timeout, 0);
    chk("no_grant_in_resp", bus.req_ready, 0);
    chk("stop_resp", bus.m_stop, 0);
    tick();
  endtask

  initial begin
    bit ok;
    n_asserts     = 0;
    n_fail        = 0;
    reset         = 1'b0;
    bus.req_valid = 4'b1101;
    bus.req_rw    = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[7*i +: 7]  = 7'(7'h10 + i);
      bus.req_wdata[8*i +: 8] = 8'(8'hA0 + i);
    end
    bus.m_busy  = 1'b0;
    bus.m_done  = 1'b0;
    bus.m_nack  = 1'b0;
    bus.m_rdata = 8'h00;

    // Reset state with requests already pending
    tick();
    tick();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_m_start", bus.m_start, 0);
    chk("rst_m_stop", bus.m_stop, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_rsp_flags", {bus.rsp_nack, bus.rsp_timeout, bus.rsp_rdata}, 0);
    reset = 1'b1;

    // Round-robin with 0,2,3 held: grants 0,2,3,0
    txn(0, 7'h10, 1'b0, 8'hA0, 1'b0, 8'h99, 8'h00, 1'b0);
    txn(2, 7'h12, 1'b0, 8'hA2, 1'b0, 8'h99, 8'h00, 1'b0);
    txn(3, 7'h13, 1'b0, 8'hA3, 1'b0, 8'h99, 8'h00, 1'b0);
    txn(0, 7'h10, 1'b0, 8'hA0, 1'b0, 8'h99, 8'h00, 1'b0);
    bus.req_valid = 4'b0000;

    // Read with NACK on requester 1
    bus.req_rw[1] = 1'b1;
    bus.req_valid = 4'b0010;
    txn(1, 7'h11, 1'b1, 8'hA1, 1'b1, 8'h3C, 8'h3C, 1'b1);

    // Single write on requester 0, read data forced to zero
    bus.req_addr[6:0]  = 7'h50;
    bus.req_wdata[7:0] = 8'hA5;
    bus.req_valid      = 4'b0001;
    txn(0, 7'h50, 1'b0, 8'hA5, 1'b0, 8'hFF, 8'h00, 1'b1);

    // Busy master holds off m_start for 10 cycles
    bus.req_valid = 4'b1000;
    bus.m_busy    = 1'b1;
    #1;
    chk("busy_ready_g3", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0000;
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      ok = ok && (bus.m_start === 1'b0) && (bus.m_stop === 1'b1);
      tick();
    end
    chk("busy_no_start", ok, 1);
    bus.m_busy = 1'b0;
    #1;
    chk("busy_start_pulse", bus.m_start, 1);
    chk("busy_addr", bus.m_addr, 7'h13);
    tick();
    chk("busy_start_once", bus.m_start, 0);
    bus.m_done = 1'b1;
    tick();
    bus.m_done = 1'b0;
    chk("busy_rsp_valid", bus.rsp_valid, 4'b1000);
    tick();

    // Timeout on a read from requester 0: response 64 cycles after entering WAIT
    bus.req_rw[0] = 1'b1;
    bus.m_rdata   = 8'h77;
    bus.req_valid = 4'b0001;
    #1;
    chk("tmo_ready_g0", bus.req_ready, 4'b0001);
    tick();
    bus.req_valid = 4'b0000;
    chk("tmo_start", bus.m_start, 1);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 64; i++) begin
      ok = ok && (bus.rsp_valid === 4'b0000) && (bus.m_stop === 1'b1);
      tick();
    end
    chk("tmo_wait_quiet", ok, 1);
    chk("tmo_rsp_valid", bus.rsp_valid, 4'b0001);
    chk("tmo_flag", bus.rsp_timeout, 1);
    chk("tmo_rdata", bus.rsp_rdata, 0);
    chk("tmo_nack", bus.rsp_nack, 0);
    tick();
    chk("tmo_rsp_one_cycle", {bus.rsp_valid, bus.rsp_timeout}, 0);

    // m_done coincident with the final count wins over timeout
    bus.req_valid = 4'b0010;
    #1;
    chk("tie_ready_g1", bus.req_ready, 4'b0010);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    ok = 1'b1;
    for (int i = 0; i < 63; i++) begin
      ok = ok && (bus.rsp_valid === 4'b0000);
      tick();
    end
    chk("tie_wait_quiet", ok, 1);
    bus.m_done  = 1'b1;
    bus.m_rdata = 8'h5A;
    tick();
    bus.m_done  = 1'b0;
    bus.m_rdata = 8'h00;
    chk("tie_rsp_valid", bus.rsp_valid, 4'b0010);
    chk("tie_timeout", bus.rsp_timeout, 0);
    chk("tie_rdata", bus.rsp_rdata, 8'h5A);
    tick();

    // Reset asserted mid-WAIT, then pending requester 2 granted from rr_ptr=0
    bus.req_valid = 4'b1000;
    #1;
    chk("rstw_ready_g3", bus.req_ready, 4'b1000);
    tick();
    bus.req_valid = 4'b0000;
    tick();
    chk("rstw_in_wait", bus.m_stop, 1);
    bus.req_valid = 4'b0100;
    #1;
    chk("rstw_no_grant_in_wait", bus.req_ready, 0);
    reset       = 1'b0;
    bus.m_done  = 1'b1;
    #1;
    chk("rstw_async_outputs",
        {bus.m_stop, bus.m_start, bus.m_rw, bus.m_addr, bus.m_wdata, bus.req_ready}, 0);
    tick();
    bus.m_done = 1'b0;
    chk("rstw_no_rsp_1", bus.rsp_valid, 0);
    tick();
    chk("rstw_no_rsp_2", {bus.rsp_valid, bus.req_ready}, 0);
    reset = 1'b1;
    txn(2, 7'h12, 1'b0, 8'hA2, 1'b0, 8'hEE, 8'h00, 1'b1);
    tick();
    chk("final_quiet", {bus.rsp_valid, bus.req_ready, bus.m_start, bus.m_stop}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
